// File: rtl/instr_decode_hs.sv
// rtl/instr_decode_hs.sv - handshaked decode stage with load-use scoreboard
//
// Decodes one 32-bit instruction per accept into a registered execute bundle.
// The register file is read combinationally in the accept cycle.
//
// Parameters:
//   DATA_W   - operand/register datapath width (>= 32)
//   NUM_CH   - audio channel count (2..16); CH_W = max(1, clog2(NUM_CH))
//   LOAD_LAT - cycles after a load issues before its destination is readable (1..7)
//
// Optional feature macro: ID_PERF_CNT_EN adds perf_issued, perf_hazard_stalls
// and perf_bp_stalls free-running 32-bit counters.
//
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   flush                           - drop the bundle being registered this cycle
//   in_valid / in_ready / if_id_reg - fetch-side handshake and instruction word
//   register_select_1/2             - rs1/rs2 register file addresses
//   selected_register_value_1/2     - register file read data
//   out_valid / out_ready           - execute-side handshake
//   alu_opcode, memory_access_code, audio_opcode       - per-class opcodes
//   operand_value1/2                - operands (register data or placed immediate)
//   register_writeback_enable       - 01 lower half, 10 upper half, 11 full word
//   writeback_register_encoding     - destination register (rs1)
//   writeback_data_select_hotcode   - {arith, mem, move} writeback source
//   audio_channel_select            - clamped audio channel
//   id_ex_instruction               - issued word, 0 when out_valid is low

module instr_decode_hs #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_CH   = 4,
    parameter  int LOAD_LAT = 2,
    localparam int CH_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       if_id_reg,
    output logic [2:0]        register_select_1,
    output logic [2:0]        register_select_2,
    input  logic [DATA_W-1:0] selected_register_value_1,
    input  logic [DATA_W-1:0] selected_register_value_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_opcode,
    output logic [4:0]        memory_access_code,
    output logic [2:0]        audio_opcode,
    output logic [DATA_W-1:0] operand_value1,
    output logic [DATA_W-1:0] operand_value2,
    output logic [1:0]        register_writeback_enable,
    output logic [2:0]        writeback_register_encoding,
    output logic [2:0]        writeback_data_select_hotcode,
    output logic [CH_W-1:0]   audio_channel_select,
    output logic [31:0]       id_ex_instruction
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_hazard_stalls,
    output logic [31:0]       perf_bp_stalls
`endif
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [2:0]        alu_op;
        logic [4:0]        mem_code;
        logic [2:0]        audio_op;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [1:0]        wb_en;
        logic [2:0]        wb_reg;
        logic [2:0]        wb_sel;
        logic [CH_W-1:0]   ch_sel;
    } bundle_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic              w_imm;
    logic [1:0]        w_type;
    logic [2:0]        w_op;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [15:0]       w_imm16;

    assign w_imm   = if_id_reg[31];
    assign w_type  = if_id_reg[30:29];
    assign w_op    = if_id_reg[28:26];
    assign w_rs1   = if_id_reg[21:19];
    assign w_rs2   = if_id_reg[18:16];
    assign w_imm16 = if_id_reg[15:0];

    assign register_select_1 = w_rs1;
    assign register_select_2 = w_rs2;

    // ------------------------------------------------------------------
    // Instruction classes
    // ------------------------------------------------------------------
    logic w_is_move;
    logic w_is_arith;
    logic w_is_mem;
    logic w_is_audio;
    logic w_is_load;
    logic w_is_store;

    assign w_is_move  = (w_type == 2'b01) &&
                        ((w_op == 3'b101) || (w_op == 3'b110) || (w_op == 3'b111));
    assign w_is_arith = (w_type == 2'b01) && !w_is_move;
    assign w_is_mem   = (w_type == 2'b10);
    assign w_is_audio = (w_type == 2'b11);
    assign w_is_load  = w_is_mem && !w_op[2] && (w_op[1:0] != 2'b00);
    assign w_is_store = w_is_mem && w_op[2];

    // Source register usage: rs1 is a source only for arith and store data;
    // everything else that touches registers reads rs2.
    logic w_use_rs1;
    logic w_use_rs2;

    assign w_use_rs1 = w_is_arith || w_is_store;
    assign w_use_rs2 = (w_is_arith && !w_imm)
                    || (w_is_move && (w_op == 3'b111))
                    || (w_is_mem && !w_imm)
                    || (w_is_audio && !w_imm);

    // ------------------------------------------------------------------
    // Load-use scoreboard: a nonzero count means the register's load data
    // is not yet available.
    // ------------------------------------------------------------------
    logic [2:0] r_sb_cnt [8];
    logic       w_busy_rs1;
    logic       w_busy_rs2;
    logic       w_hazard;
    logic       w_slot_free;
    logic       w_accept;

    assign w_busy_rs1  = (r_sb_cnt[w_rs1] != 3'd0);
    assign w_busy_rs2  = (r_sb_cnt[w_rs2] != 3'd0);
    assign w_hazard    = in_valid && ((w_use_rs1 && w_busy_rs1) || (w_use_rs2 && w_busy_rs2));

    logic r_out_valid;

    // The output slot can take a new bundle when it is empty or being drained.
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !reset && !w_hazard && w_slot_free;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (reset) begin
                r_sb_cnt[i] <= 3'd0;
            end else if (w_accept && w_is_load && (w_rs1 == 3'(i))) begin
                r_sb_cnt[i] <= 3'(LOAD_LAT);
            end else if (r_sb_cnt[i] != 3'd0) begin
                r_sb_cnt[i] <= r_sb_cnt[i] - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Immediate placement and channel clamp
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_imm_lo;
    logic [DATA_W-1:0] w_imm_hi;
    logic [DATA_W-1:0] w_imm_mid;
    logic [CH_W-1:0]   w_ch_raw;
    logic [CH_W-1:0]   w_ch_sel;

    // DATA_W >= 32, so shifting the zero-extended imm16 never reaches bit 32.
    assign w_imm_lo  = DATA_W'(w_imm16);
    assign w_imm_hi  = w_imm_lo << 16;
    assign w_imm_mid = w_imm_lo << 8;

    assign w_ch_raw = if_id_reg[25 -: CH_W];
    assign w_ch_sel = (int'(w_ch_raw) >= NUM_CH) ? CH_W'(NUM_CH - 1) : w_ch_raw;

    // ------------------------------------------------------------------
    // Bundle decode
    // Operand placement:
    //   arith : op1 = rs1 data, op2 = imm ? imm16 : rs2 data
    //   move  : op2 = imm16 (101), imm16<<16 (110), rs2 data (111)
    //   mem   : op1 = store data (rs1), op2 = address imm ? imm16 : rs2 data
    //   audio : op1 = imm ? placed imm : rs2 data
    // ------------------------------------------------------------------
    bundle_t w_dec;

    always_comb begin
        w_dec        = '0;
        w_dec.instr  = if_id_reg;
        w_dec.wb_reg = w_rs1;
        w_dec.ch_sel = w_ch_sel;

        if (w_is_arith) begin
            w_dec.alu_op = w_op;
            w_dec.op1    = selected_register_value_1;
            w_dec.op2    = w_imm ? w_imm_lo : selected_register_value_2;
            w_dec.wb_en  = 2'b11;
            w_dec.wb_sel = 3'b100;
        end

        if (w_is_move) begin
            w_dec.wb_sel = 3'b001;
            case (w_op)
                3'b101: begin
                    w_dec.op2   = w_imm_lo;
                    w_dec.wb_en = 2'b01;
                end
                3'b110: begin
                    w_dec.op2   = w_imm_hi;
                    w_dec.wb_en = 2'b10;
                end
                default: begin
                    w_dec.op2   = selected_register_value_2;
                    w_dec.wb_en = 2'b11;
                end
            endcase
        end

        if (w_is_mem) begin
            w_dec.mem_code = {w_op[2], w_op[1], w_op[1], w_op[0], w_op[0]};
            w_dec.op1      = w_is_store ? selected_register_value_1 : '0;
            w_dec.op2      = w_imm ? w_imm_lo : selected_register_value_2;
            if (w_is_load) begin
                // Load width follows op[1:0]: 01 lower, 10 upper, 11 full.
                w_dec.wb_en  = w_op[1:0];
                w_dec.wb_sel = 3'b010;
            end
        end

        if (w_is_audio) begin
            w_dec.audio_op = w_op;
            if (!w_imm) begin
                w_dec.op1 = selected_register_value_2;
            end else if (w_op == 3'b100) begin
                w_dec.op1 = w_imm_hi;
            end else if (w_op == 3'b110) begin
                w_dec.op1 = w_imm_mid;
            end else begin
                w_dec.op1 = w_imm_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register. Whenever the slot goes empty the bundle is zeroed so
    // no stale writeback enable can leak into execute.
    // ------------------------------------------------------------------
    bundle_t r_bundle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (flush || (!w_accept && w_slot_free)) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_dec;
        end
    end

    assign out_valid                     = r_out_valid;
    assign id_ex_instruction             = r_bundle.instr;
    assign alu_opcode                    = r_bundle.alu_op;
    assign memory_access_code            = r_bundle.mem_code;
    assign audio_opcode                  = r_bundle.audio_op;
    assign operand_value1                = r_bundle.op1;
    assign operand_value2                = r_bundle.op2;
    assign register_writeback_enable     = r_bundle.wb_en;
    assign writeback_register_encoding   = r_bundle.wb_reg;
    assign writeback_data_select_hotcode = r_bundle.wb_sel;
    assign audio_channel_select          = r_bundle.ch_sel;

`ifdef ID_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally, cleared only by reset)
    // ------------------------------------------------------------------
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_hazard;
    logic [31:0] r_perf_bp;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_issued <= 32'd0;
            r_perf_hazard <= 32'd0;
            r_perf_bp     <= 32'd0;
        end else begin
            if (w_accept && (w_type != 2'b00)) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (w_hazard && w_slot_free) begin
                r_perf_hazard <= r_perf_hazard + 32'd1;
            end
            if (r_out_valid && !out_ready) begin
                r_perf_bp <= r_perf_bp + 32'd1;
            end
        end
    end

    assign perf_issued        = r_perf_issued;
    assign perf_hazard_stalls = r_perf_hazard;
    assign perf_bp_stalls     = r_perf_bp;
`endif

endmodule

// File: tb/tb_instr_decode_hs.sv
// tb/tb_instr_decode_hs.sv - self-checking bench for instr_decode_hs

module tb_instr_decode_hs;

    localparam int DW  = 40;
    localparam int NCH = 3;
    localparam int LL  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   if_id_reg;
    logic [2:0]    register_select_1;
    logic [2:0]    register_select_2;
    logic [DW-1:0] selected_register_value_1;
    logic [DW-1:0] selected_register_value_2;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    alu_opcode;
    logic [4:0]    memory_access_code;
    logic [2:0]    audio_opcode;
    logic [DW-1:0] operand_value1;
    logic [DW-1:0] operand_value2;
    logic [1:0]    register_writeback_enable;
    logic [2:0]    writeback_register_encoding;
    logic [2:0]    writeback_data_select_hotcode;
    logic [1:0]    audio_channel_select;
    logic [31:0]   id_ex_instruction;
`ifdef ID_PERF_CNT_EN
    logic [31:0]   perf_issued;
    logic [31:0]   perf_hazard_stalls;
    logic [31:0]   perf_bp_stalls;
`endif

    instr_decode_hs #(.DATA_W(DW), .NUM_CH(NCH), .LOAD_LAT(LL)) dut (
        .clock                         (clock),
        .reset                         (reset),
        .flush                         (flush),
        .in_valid                      (in_valid),
        .in_ready                      (in_ready),
        .if_id_reg                     (if_id_reg),
        .register_select_1             (register_select_1),
        .register_select_2             (register_select_2),
        .selected_register_value_1     (selected_register_value_1),
        .selected_register_value_2     (selected_register_value_2),
        .out_valid                     (out_valid),
        .out_ready                     (out_ready),
        .alu_opcode                    (alu_opcode),
        .memory_access_code            (memory_access_code),
        .audio_opcode                  (audio_opcode),
        .operand_value1                (operand_value1),
        .operand_value2                (operand_value2),
        .register_writeback_enable     (register_writeback_enable),
        .writeback_register_encoding   (writeback_register_encoding),
        .writeback_data_select_hotcode (writeback_data_select_hotcode),
        .audio_channel_select          (audio_channel_select),
        .id_ex_instruction             (id_ex_instruction)
`ifdef ID_PERF_CNT_EN
        ,
        .perf_issued                   (perf_issued),
        .perf_hazard_stalls            (perf_hazard_stalls),
        .perf_bp_stalls                (perf_bp_stalls)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  alu;
        logic [4:0]  mem;
        logic [2:0]  aud;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [1:0]  wb;
        logic [2:0]  wbreg;
        logic [2:0]  hot;
        logic [1:0]  ch;
    } exp_t;

    function automatic int f_type(input logic [31:0] w);
        return int'((w >> 29) & 32'd3);
    endfunction

    function automatic int f_op(input logic [31:0] w);
        return int'((w >> 26) & 32'd7);
    endfunction

    function automatic bit f_imm(input logic [31:0] w);
        return w >= 32'h8000_0000;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] w);
        int t = f_type(w);
        int o = f_op(w);
        return (t == 1 && o < 5) || (t == 2 && o >= 4);
    endfunction

    function automatic bit reads_rs2(input logic [31:0] w);
        int t = f_type(w);
        int o = f_op(w);
        bit i = f_imm(w);
        return (t == 1 && o < 5 && !i) || (t == 1 && o == 7) || (t == 2 && !i) || (t == 3 && !i);
    endfunction

    function automatic bit is_load(input logic [31:0] w);
        return f_type(w) == 2 && f_op(w) >= 1 && f_op(w) <= 3;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int t = f_type(w);
        int o = f_op(w);
        bit i = f_imm(w);
        longint unsigned k = longint'(w % 65536);
        int chv = int'((w >> 24) % 4);
        e = '0;
        e.instr = w;
        e.wbreg = 3'((w >> 19) % 8);
        e.ch    = 2'((chv > NCH - 1) ? NCH - 1 : chv);
        if (t == 1 && o >= 5) begin
            e.hot = 3'd1;
            if (o == 5) begin e.op2 = k;         e.wb = 2'd1; end
            if (o == 6) begin e.op2 = k * 65536; e.wb = 2'd2; end
            if (o == 7) begin e.op2 = 64'(b);    e.wb = 2'd3; end
        end else if (t == 1) begin
            e.alu = 3'(o);
            e.op1 = 64'(a);
            e.op2 = i ? k : 64'(b);
            e.wb  = 2'd3;
            e.hot = 3'd4;
        end else if (t == 2) begin
            e.mem = 5'((o / 4) * 16 + ((o / 2) % 2) * 12 + (o % 2) * 3);
            e.op1 = (o >= 4) ? 64'(a) : 64'd0;
            e.op2 = i ? k : 64'(b);
            if (o >= 1 && o <= 3) begin
                e.wb  = 2'(o);
                e.hot = 3'd2;
            end
        end else if (t == 3) begin
            e.aud = 3'(o);
            if (!i)          e.op1 = 64'(b);
            else if (o == 4) e.op1 = k * 65536;
            else if (o == 6) e.op1 = k * 256;
            else             e.op1 = k;
        end
        return e;
    endfunction

    // Reference state: registered bundle plus, per register, the first cycle
    // at which a pending load's destination may be read.
    bit          m_valid = 1'b0;
    exp_t        m_out   = '0;
    longint      ready_at [8];
    longint      cyc     = 0;
    logic [31:0] m_issued = 0;
    logic [31:0] m_hz     = 0;
    logic [31:0] m_bp     = 0;
    bit          obs_ready;

    task automatic step(input bit rst, input bit fl, input bit iv, input logic [31:0] w,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ordy);
        bit haz;
        bit exp_rdy;
        bit acc;
        int r1;
        int r2;
        reset = rst; flush = fl; in_valid = iv; if_id_reg = w;
        selected_register_value_1 = a; selected_register_value_2 = b; out_ready = ordy;
        #1;
        r1 = int'((w >> 19) % 8);
        r2 = int'((w >> 16) % 8);
        haz = iv && ((reads_rs1(w) && ready_at[r1] > cyc) || (reads_rs2(w) && ready_at[r2] > cyc));
        exp_rdy = !rst && !haz && (!m_valid || ordy);
        check("in_ready", in_ready, exp_rdy);
        check("rs1_sel", register_select_1, r1);
        check("rs2_sel", register_select_2, r2);
        obs_ready = in_ready;
        acc = iv && exp_rdy;
        if (rst) begin
            m_valid = 0; m_out = '0; m_issued = 0; m_hz = 0; m_bp = 0;
            for (int r = 0; r < 8; r++) ready_at[r] = 0;
        end else begin
            if (acc && f_type(w) != 0) m_issued++;
            if (haz && (!m_valid || ordy)) m_hz++;
            if (m_valid && !ordy) m_bp++;
            if (acc && is_load(w)) ready_at[r1] = cyc + 1 + LL;
            if (fl) begin
                m_valid = 0; m_out = '0;
            end else if (acc) begin
                m_valid = 1; m_out = ref_decode(w, a, b);
            end else if (!m_valid || ordy) begin
                m_valid = 0; m_out = '0;
            end
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
        check("out_valid", out_valid, m_valid);
        check("id_ex_instr", id_ex_instruction, m_valid ? m_out.instr : 32'd0);
        if (m_valid) begin
            check("alu_op", alu_opcode, m_out.alu);
            check("mem_code", memory_access_code, m_out.mem);
            check("audio_op", audio_opcode, m_out.aud);
            check("operand1", operand_value1, m_out.op1);
            check("operand2", operand_value2, m_out.op2);
            check("wb_en", register_writeback_enable, m_out.wb);
            check("wb_reg", writeback_register_encoding, m_out.wbreg);
            check("wb_hot", writeback_data_select_hotcode, m_out.hot);
            check("ch_sel", audio_channel_select, m_out.ch);
        end
`ifdef ID_PERF_CNT_EN
        check("perf_issued", perf_issued, m_issued);
        check("perf_hazard", perf_hazard_stalls, m_hz);
        check("perf_bp", perf_bp_stalls, m_bp);
`endif
    endtask

    localparam logic [31:0] ARITH  = 32'h2008_8000;
    localparam logic [31:0] ARITH2 = 32'h2408_8001;
    localparam logic [31:0] LD_R4  = 32'hCC20_0010;
    localparam logic [31:0] USE_R4 = 32'hA020_0003;

    initial begin
        int stalls;
        int bubbles;
        bit done;
        bit rr;
        bit ff;
        bit vv;
        bit oo;
        bit held;
        logic [31:0] w;
        logic [63:0] t1;
        logic [63:0] t2;

        for (int r = 0; r < 8; r++) ready_at[r] = 0;
        reset = 1; flush = 0; in_valid = 0; if_id_reg = 0; out_ready = 0;
        selected_register_value_1 = 0; selected_register_value_2 = 0;
        @(negedge clock);

        // Reset state
        step(1, 0, 1, ARITH, 0, 0, 1);
        check("rst_ready", obs_ready, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("rst_valid", out_valid, 0);
        check("rst_wb_en", register_writeback_enable, 0);

        // Basic arith
        step(0, 0, 1, ARITH, 5, 7, 1);
        check("add_valid", out_valid, 1);
        check("add_op1", operand_value1, 5);
        check("add_op2", operand_value2, 7);
        check("add_wb", register_writeback_enable, 2'b11);
        check("add_hot", writeback_data_select_hotcode, 3'b100);

        // Load-use: two stall cycles, two bubbles
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, LD_R4, 11, 22, 1);
        stalls = 0; bubbles = 0; done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            step(0, 0, 1, USE_R4, 40'h33, 40'h44, 1);
            if (obs_ready) done = 1;
            else begin
                stalls++;
                if (!out_valid) bubbles++;
            end
        end
        check("lu_done", done, 1);
        check("lu_stalls", stalls, 2);
        check("lu_bubbles", bubbles, 2);
        check("lu_issue", id_ex_instruction, USE_R4);
`ifdef ID_PERF_CNT_EN
        check("lu_perf_hz", perf_hazard_stalls, 2);
`endif

        // Immediate placement
        step(0, 0, 1, 32'h3830_BEEF, 1, 2, 1);
        check("mvu_op2", operand_value2, 64'hBEEF_0000);
        check("mvu_wb", register_writeback_enable, 2'b10);
        step(0, 0, 1, 32'hF800_1234, 1, 2, 1);
        check("aper_op1", operand_value1, 64'h0012_3400);

        // Channel clamp
        step(0, 0, 1, 32'hE300_0000, 1, 2, 1);
        check("ch_clamp", audio_channel_select, 2);

        // Backpressure hold
        step(0, 0, 1, ARITH, 9, 8, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, ARITH2, 3, 4, 0);
            check("bp_ready", obs_ready, 0);
            check("bp_hold", id_ex_instruction, ARITH);
            check("bp_op1", operand_value1, 9);
        end
        step(0, 0, 1, ARITH2, 3, 4, 1);
        check("bp_release", obs_ready, 1);
        check("bp_next", id_ex_instruction, ARITH2);

        // Flush with reset mid-stall clears scoreboard
        step(0, 0, 1, LD_R4, 1, 2, 1);
        step(0, 0, 1, USE_R4, 1, 2, 1);
        check("fr_stall", obs_ready, 0);
        step(1, 1, 1, USE_R4, 1, 2, 0);
        check("fr_valid", out_valid, 0);
        check("fr_instr", id_ex_instruction, 0);
        check("fr_op1", operand_value1, 0);
        check("fr_wb", register_writeback_enable, 0);
        step(0, 0, 1, USE_R4, 1, 2, 1);
        check("fr_sb_clear", obs_ready, 1);

        // Flush alone: counters keep running
        step(0, 0, 1, LD_R4, 1, 2, 1);
        step(0, 1, 0, 0, 1, 2, 1);
        check("fl_valid", out_valid, 0);
        check("fl_instr", id_ex_instruction, 0);
        stalls = 0; done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            step(0, 0, 1, USE_R4, 5, 6, 1);
            if (obs_ready) done = 1;
            else stalls++;
        end
        check("fl_done", done, 1);
        check("fl_stalls", stalls, 1);

        // Randomized traffic
        held = 0; w = 0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            ff = ($urandom_range(0, 29) == 0);
            vv = ($urandom_range(0, 9) < 8);
            oo = ($urandom_range(0, 9) < 7);
            if (!held) w = $urandom();
            t1 = {$urandom(), $urandom()};
            t2 = {$urandom(), $urandom()};
            step(rr, ff, vv, w, t1[DW-1:0], t2[DW-1:0], oo);
            held = vv && !obs_ready && !rr;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
